p2s_tx: RTL and testbench
=========================

Name: p2s_tx

Overview:
- Parallel-to-serial transmitter. It is the sending end for the team's serial-to-parallel receiver.
- Accepts a WIDTH-bit word through a load/ready handshake and shifts it out on a single serial line, one bit per enabled clock.
- Sits between a parallel data source (register file, FIFO) and the serial link.
- Supports stall via a bit enable, and back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, word length in bits; must be >= 2.
- MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first.
- IDLE_LEVEL, 0, level driven on serout when no word is in flight.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset: rst=0 resets immediately, independent of clk.
- parin  input  WIDTH  parallel word; sampled only on an accept edge.
- load  input  1  source offers parin this cycle.
- en  input  1  bit strobe; the current bit advances only on edges where en=1.
- ready  output  1  transmitter can accept a word this cycle.
- serout  output  1  serial data.
- sout_valid  output  1  serout carries a data bit.
- done  output  1  the current bit is the last bit of a word and is consumed at this edge.

Behaviour:
- Reset (rst=0), applied asynchronously:
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: serout=IDLE_LEVEL, sout_valid=0, done=0, ready=1.
- States: IDLE, SHIFT. Bit counter is $clog2(WIDTH) bits and counts 0..WIDTH-1.
- Output decode (all from registers, no parin/load paths):
  - sout_valid = (state==SHIFT).
  - serout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0], while in SHIFT; IDLE_LEVEL in IDLE.
  - done = SHIFT && en && cnt==WIDTH-1.
  - ready = IDLE || done.
- Accept: occurs on a rising edge with load=1 and ready=1.
  - shreg<=parin, cnt<=0, state<=SHIFT.
  - From IDLE, acceptance does not require en.
- Latency: the first bit appears on serout in the cycle right after the accept edge.
- SHIFT, en=1, cnt<WIDTH-1:
  - Shift shreg one place toward the output end; the vacated bit fills with 0.
  - cnt<=cnt+1.
- SHIFT, en=0: shreg, cnt and state hold; serout holds the current bit (stall of any length).
- SHIFT, en=1, cnt==WIDTH-1 (done=1):
  - If load=1, accept the new word and stay in SHIFT. Serial stream stays contiguous; sout_valid does not drop.
  - Otherwise state<=IDLE.
- One word therefore occupies exactly WIDTH enabled cycles.
- load with ready=0 (mid-word, not in the done cycle): ignored; parin is not sampled and the word in flight is unaffected. The source must hold load until ready.
- IDLE with load=0: outputs stay static; en has no effect.
- Reset mid-word: the word is aborted, outputs return to reset values immediately, and no partial done is generated. After rst returns to 1, the next accepted word starts from bit 0.
- Simultaneous load and reset: reset wins; the word is not accepted.

Test Plan:
- Basic MSB-first (WIDTH=8, MSB_FIRST=1, en=1): load 8'hB2 from IDLE.
  - serout = 1,0,1,1,0,0,1,0 on the 8 cycles after accept.
  - sout_valid=1 for exactly 8 cycles; done=1 only in the 8th.
  - Then serout=0, ready=1.
- LSB-first (MSB_FIRST=0): load 8'hB2 -> serout = 0,1,0,0,1,1,0,1; same sout_valid/done timing.
- Back-to-back: load 8'hB2, then hold load=1 with 8'h0F until accepted in the done cycle.
  - 16 contiguous bits: 1,0,1,1,0,0,1,0,0,0,0,0,1,1,1,1.
  - sout_valid never deasserts; done pulses at bit 8 and bit 16.
- Stall: during 8'hB2, drive en=0 for 3 cycles while the 3rd bit (1) is on serout.
  - That bit is held for 4 cycles; total word duration is 11 cycles.
  - Remaining bits unchanged; done only on the final enabled cycle.
- Load while busy: during 8'hB2, pulse load=1 with parin=8'hFF at bit 4 (ready=0).
  - Output stream is still exactly 8'hB2.
  - No word follows; ready returns to 1 afterwards.
- Reset mid-word: assert rst=0 asynchronously (between clock edges) after 4 bits of 8'hB2.
  - serout=0, sout_valid=0, ready=1 immediately, without waiting for a clock edge.
  - After release, load 8'h0F -> serout = 0,0,0,0,1,1,1,1, starting cleanly.

Source files
------------

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on load/ready and
// shifts it out one bit per enabled clock, back-to-back words without a gap.
module p2s_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parin,
  input  logic             load,
  input  logic             en,
  output logic             ready,
  output logic             serout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last_bit;
  logic             accept;
  logic             out_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // The output end of the shift register and the shift direction follow MSB_FIRST.
  generate
    if (MSB_FIRST) begin : g_msb
      assign out_bit       = shreg_q[WIDTH-1];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign out_bit       = shreg_q[0];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == LAST);
  assign accept   = load && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // A load in the done cycle chains the next word with no idle gap.
        if (done) begin
          state_d = load ? S_SHIFT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shreg_d = parin;
      cnt_d   = '0;
    end else if ((state_q == S_SHIFT) && en) begin
      shreg_d = shreg_shifted;
      cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    sout_valid = (state_q == S_SHIFT);
    done       = sout_valid && en && last_bit;
    ready      = (state_q == S_IDLE) || done;
    serout     = sout_valid ? out_bit : IDLE_LEVEL;
  end

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word/bit-index reference model.
module tb_p2s_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] parin;
  logic       load;
  logic       en;

  logic rdy_m, ser_m, val_m, done_m;
  logic rdy_l, ser_l, val_l, done_l;

  int total = 0;
  int bad   = 0;

  // Reference model: word in flight and index of the bit currently on the line.
  logic       m_busy = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_idx  = 0;

  // Observed stream, rebuilt from consumed bits.
  logic [15:0] cap_m;
  logic [7:0]  cap_l;
  int          nvalid;
  int          ndone;

  always #5 clk = ~clk;

  p2s_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .parin(parin), .load(load), .en(en),
    .ready(rdy_m), .serout(ser_m), .sout_valid(val_m), .done(done_m)
  );

  p2s_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .parin(parin), .load(load), .en(en),
    .ready(rdy_l), .serout(ser_l), .sout_valid(val_l), .done(done_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    cap_m  = '0;
    cap_l  = '0;
    nvalid = 0;
    ndone  = 0;
  endtask

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(input logic l, input logic [7:0] p, input logic e);
    logic exp_done, exp_ready, exp_sm, exp_sl;
    @(negedge clk);
    load  = l;
    parin = p;
    en    = e;
    #1;
    exp_done  = m_busy && e && (m_idx == 7);
    exp_ready = !m_busy || exp_done;
    exp_sm    = m_busy ? m_word[7 - m_idx] : 1'b0;
    exp_sl    = m_busy ? m_word[m_idx]     : 1'b0;
    chk("serout_msb", 32'(ser_m), 32'(exp_sm));
    chk("serout_lsb", 32'(ser_l), 32'(exp_sl));
    chk("sout_valid", 32'({val_m, val_l}), 32'({m_busy, m_busy}));
    chk("done", 32'({done_m, done_l}), 32'({exp_done, exp_done}));
    chk("ready", 32'({rdy_m, rdy_l}), 32'({exp_ready, exp_ready}));
    if (val_m && e) begin
      cap_m = {cap_m[14:0], ser_m};
      cap_l = {ser_l, cap_l[7:1]};
    end
    if (val_m) nvalid++;
    if (done_m) ndone++;
    @(posedge clk);
    if (l && exp_ready) begin
      m_busy = 1'b1;
      m_word = p;
      m_idx  = 0;
    end else if (m_busy && e) begin
      if (m_idx == 7) m_busy = 1'b0;
      else m_idx++;
    end
  endtask

  initial begin
    rst   = 1'b0;
    load  = 1'b0;
    en    = 1'b0;
    parin = 8'h00;
    #1;
    chk("reset_state", 32'({rdy_m, ser_m, val_m, done_m}), 32'(4'b1000));
    @(negedge clk);
    rst = 1'b1;

    // Basic word, both bit orders.
    clr();
    step(1'b1, 8'hB2, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
    chk("basic_msb_stream", 32'(cap_m[7:0]), 32'h0000_00B2);
    chk("basic_lsb_stream", 32'(cap_l), 32'h0000_00B2);
    chk("basic_valid_cycles", 32'(nvalid), 32'd8);
    chk("basic_done_count", 32'(ndone), 32'd1);
    $display("basic: msb=%0h lsb=%0h", cap_m[7:0], cap_l);

    // Back-to-back: second word held on load until taken in the done cycle.
    clr();
    step(1'b1, 8'hB2, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("b2b_stream", 32'(cap_m), 32'h0000_B20F);
    chk("b2b_valid_cycles", 32'(nvalid), 32'd16);
    chk("b2b_done_count", 32'(ndone), 32'd2);
    $display("back_to_back: stream=%0h", cap_m);

    // Stall for 3 cycles while the 3rd bit is on the line.
    clr();
    step(1'b1, 8'hB2, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    chk("stall_stream", 32'(cap_m[7:0]), 32'h0000_00B2);
    chk("stall_duration", 32'(nvalid), 32'd11);
    chk("stall_done_count", 32'(ndone), 32'd1);
    $display("stall: stream=%0h cycles=%0d", cap_m[7:0], nvalid);

    // Load while busy must be ignored.
    clr();
    step(1'b1, 8'hB2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("busy_load_stream", 32'(cap_m[7:0]), 32'h0000_00B2);
    chk("busy_load_valid", 32'(nvalid), 32'd8);
    $display("load_while_busy: stream=%0h", cap_m[7:0]);

    // Asynchronous reset mid-word, with a load held across the reset edge.
    step(1'b1, 8'hB2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    en   = 1'b1;
    load = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({rdy_m, ser_m, val_m, done_m}), 32'(4'b1000));
    chk("async_reset_lsb", 32'({rdy_l, ser_l, val_l, done_l}), 32'(4'b1000));
    m_busy = 1'b0;
    load   = 1'b1;
    parin  = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    clr();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
    chk("post_reset_stream", 32'(cap_m[7:0]), 32'h0000_000F);
    chk("post_reset_valid", 32'(nvalid), 32'd8);
    $display("reset_mid_word: restart stream=%0h", cap_m[7:0]);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    $display("random: 400 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
